usb_tx_serializer: RTL

Transmit-side bit engine for the USB full-speed link. It accepts packet bytes over a valid/ready handshake and optionally prefixes SYNC. It serializes bytes LSB-first at one bit per CLKS_PER_BIT clocks, inserts stuff bits, NRZI-encodes, appends EOP and drives the differential pair. It sits between the output buffer and the bus pads, opposite the receive timer/shifter path.

---
 rtl/usb_tx_serializer_pkg.sv | 21 ++
 rtl/usb_tx_serializer_if.sv | 12 +
 rtl/usb_tx_serializer_bit_timer.sv | 32 +++
 rtl/usb_tx_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_serializer_pkg.sv
// Shared USB transmit definitions: FSM state type, SYNC pattern, stuffing limit
// and line encodings used by both transmit and receive paths.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_e;

   localparam logic [7:0] SYNC_BYTE   = 8'h80;
   localparam logic [2:0] STUFF_LIMIT = 3'd6;

   // Line encodings as {d_plus, d_minus}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Byte handshake between the output buffer (master) and the transmit serializer (slave).
interface usb_tx_serializer_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/usb_tx_serializer_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while not cleared, tick_o marks the last clock.
module tx_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam logic [3:0] TC = 4'(CLKS_PER_BIT - 1);

   logic [3:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q + 4'd1;
      if (clr_i || tick_o) begin
         cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit bit engine: holding register, shifter, bit stuffing, NRZI and EOP.
// Define USB_TX_SYNC_EN to generate SYNC internally; otherwise upstream sends 0x80 first.
//
// state      | meaning
// IDLE       | line at J, waiting for a byte in the holding register
// SYNC       | shifting the internal SYNC byte
// DATA       | shifting packet bytes, stuffing after six 1s
// EOP_SE0    | two bit periods of SE0
// EOP_J      | one bit period of J, then back to IDLE
module usb_tx_serializer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic               clk,
   input  logic               n_rst,
   usb_tx_serializer_if.slave tx,
   output logic               d_plus,
   output logic               d_minus,
   output logic               tx_busy,
   output logic               tx_done,
   output logic               tx_error
);

   tx_state_e  state_q, state_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_last_q, hold_last_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] sh_q, sh_d;
   logic [3:0] sh_cnt_q, sh_cnt_d;
   logic       last_q, last_d;
   logic [2:0] ones_q, ones_d;
   logic       nrzi_j_q, nrzi_j_d;
   logic [1:0] line_q, line_d;
   logic       eop_q, eop_d;
   logic       abort_q, abort_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic       tick, accept, take, emit, emit_bit;

   tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk    (clk),
      .n_rst  (n_rst),
      .clr_i  (state_q == ST_IDLE),
      .tick_o (tick)
   );

   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_last_d = hold_last_q;
      hold_full_d = hold_full_q;
      sh_d        = sh_q;
      sh_cnt_d    = sh_cnt_q;
      last_d      = last_q;
      ones_d      = ones_q;
      nrzi_j_d    = nrzi_j_q;
      line_d      = line_q;
      eop_d       = eop_q;
      abort_d     = abort_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      take        = 1'b0;
      emit        = 1'b0;
      emit_bit    = 1'b0;
      accept      = tx.tx_valid & ~hold_full_q;

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
`ifdef USB_TX_SYNC_EN
               state_d  = ST_SYNC;
               sh_d     = {1'b0, SYNC_BYTE[7:1]};
               sh_cnt_d = 4'd7;
               emit     = 1'b1;
               emit_bit = SYNC_BYTE[0];
`else
               state_d  = ST_DATA;
               take     = 1'b1;
`endif
            end
         end
`ifdef USB_TX_SYNC_EN
         ST_SYNC,
`endif
         ST_DATA: begin
            if (tick) begin
               // A pending stuff bit preempts shifting, byte boundaries and EOP
               if (ones_q == STUFF_LIMIT) begin
                  emit = 1'b1;
               end else if (sh_cnt_q != 4'd0) begin
                  emit     = 1'b1;
                  emit_bit = sh_q[0];
                  sh_d     = {1'b0, sh_q[7:1]};
                  sh_cnt_d = sh_cnt_q - 4'd1;
               end else if ((state_q == ST_DATA) && last_q) begin
                  state_d = ST_EOP_SE0;
                  line_d  = LINE_SE0;
                  eop_d   = 1'b0;
               end else if (hold_full_q) begin
                  state_d = ST_DATA;
                  take    = 1'b1;
               end else begin
                  state_d = ST_EOP_SE0;
                  line_d  = LINE_SE0;
                  eop_d   = 1'b0;
                  error_d = 1'b1;
                  abort_d = 1'b1;
               end
            end
         end
         ST_EOP_SE0: begin
            if (tick) begin
               if (!eop_q) begin
                  eop_d = 1'b1;
               end else begin
                  state_d = ST_EOP_J;
                  line_d  = LINE_J;
               end
            end
         end
         ST_EOP_J: begin
            if (tick) begin
               state_d  = ST_IDLE;
               line_d   = LINE_J;
               nrzi_j_d = 1'b1;
               ones_d   = 3'd0;
               abort_d  = 1'b0;
               done_d   = ~abort_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         emit        = 1'b1;
         emit_bit    = hold_data_q[0];
         sh_d        = {1'b0, hold_data_q[7:1]};
         sh_cnt_d    = 4'd7;
         last_d      = hold_last_q;
         hold_full_d = 1'b0;
      end

      if (emit) begin
         if (emit_bit) begin
            ones_d = ones_q + 3'd1;
         end else begin
            ones_d   = 3'd0;
            nrzi_j_d = ~nrzi_j_q;
         end
         line_d = nrzi_j_d ? LINE_J : LINE_K;
      end

      if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = tx.tx_data;
         hold_last_d = tx.tx_last;
      end
      // After an underrun abort, late bytes are dropped until the packet ends
      if (abort_q) begin
         hold_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         hold_data_q <= 8'd0;
         hold_last_q <= 1'b0;
         hold_full_q <= 1'b0;
         sh_q        <= 8'd0;
         sh_cnt_q    <= 4'd0;
         last_q      <= 1'b0;
         ones_q      <= 3'd0;
         nrzi_j_q    <= 1'b1;
         line_q      <= LINE_J;
         eop_q       <= 1'b0;
         abort_q     <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_last_q <= hold_last_d;
         hold_full_q <= hold_full_d;
         sh_q        <= sh_d;
         sh_cnt_q    <= sh_cnt_d;
         last_q      <= last_d;
         ones_q      <= ones_d;
         nrzi_j_q    <= nrzi_j_d;
         line_q      <= line_d;
         eop_q       <= eop_d;
         abort_q     <= abort_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign tx.tx_ready = ~hold_full_q;
   assign d_plus      = line_q[1];
   assign d_minus     = line_q[0];
   assign tx_busy     = (state_q != ST_IDLE);
   assign tx_done     = done_q;
   assign tx_error    = error_q;

endmodule
